mem_stage_ls: RTL and testbench

MEM_STAGE_LS -- requirements
Module: mem_stage_ls

---
 rtl/mem_stage_pkg.sv | 52 +++++
 rtl/mem_ls_align.sv | 85 ++++++++
 rtl/mem_stage_ls.sv | 253 +++++++++++++++++++++++++
 tb/tb_mem_stage_ls.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the load/store memory stage.
//   - XlenDefault  : default datapath width
//   - size_e       : access size encoding (11 is reserved and behaves as word)
//   - branch_op_e  : branch condition encoding
//   - state_e      : memory-stage FSM states
//   - branch_cond  : evaluates a branch condition from the ALU flags
//   - size_bytes   : number of bytes touched by an access size
package mem_stage_pkg;

    localparam int unsigned XlenDefault = 32;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeRsvd = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        BrEq = 2'b00,
        BrNe = 2'b01,
        BrLt = 2'b10,
        BrGe = 2'b11
    } branch_op_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    function automatic logic branch_cond(branch_op_e op, logic zero, logic negative);
        logic taken;
        unique case (op)
            BrEq:    taken = zero;
            BrNe:    taken = ~zero;
            BrLt:    taken = negative;
            default: taken = ~negative;
        endcase
        return taken;
    endfunction

    function automatic int unsigned size_bytes(size_e size);
        int unsigned n;
        unique case (size)
            SizeByte: n = 1;
            SizeHalf: n = 2;
            default:  n = 4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ls_align.sv
// mem_ls_align: byte-lane handling for the load/store stage.
//   Purely combinational. Produces the store lane mask and lane-shifted store data,
//   extracts and sign/zero-extends load data from a full memory word, and flags
//   misaligned accesses.
//   Build option MEM_STAGE_SUBWORD_EN: when defined, byte/half accesses are honoured;
//   when undefined, i_size and i_unsigned are ignored and every access is a
//   sign-extended word.
// Ports:
//   i_size       access size (size_e encoding)
//   i_unsigned   zero-extend loads when set
//   i_addr_lo    byte offset of the access within the memory word
//   i_wdata      store data, right-aligned
//   i_mem_word   memory word currently addressed
//   o_misaligned access crosses its natural alignment
//   o_lane_mask  byte lanes written by a store
//   o_wdata      store data shifted onto its byte lanes
//   o_rdata      load result, extended to XLEN
module mem_ls_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN = XlenDefault
) (
    input  logic [1:0]                    i_size,
    input  logic                          i_unsigned,
    input  logic [$clog2(XLEN/8)-1:0]     i_addr_lo,
    input  logic [XLEN-1:0]               i_wdata,
    input  logic [XLEN-1:0]               i_mem_word,
    output logic                          o_misaligned,
    output logic [XLEN/8-1:0]             o_lane_mask,
    output logic [XLEN-1:0]               o_wdata,
    output logic [XLEN-1:0]               o_rdata
);

    localparam int unsigned NumBytes = XLEN / 8;

    size_e          size_eff;
    logic           unsigned_eff;
    int unsigned    nbytes;
    int unsigned    nbits;
    int unsigned    off;
    logic [XLEN-1:0] shifted;
    logic           ext_bit;

`ifdef MEM_STAGE_SUBWORD_EN
    assign size_eff     = size_e'(i_size);
    assign unsigned_eff = i_unsigned;
`else
    logic unused_subword;
    assign unused_subword = ^{i_size, i_unsigned};
    assign size_eff       = SizeWord;
    assign unsigned_eff   = 1'b0;
`endif

    always_comb begin
        nbytes = size_bytes(size_eff);
        nbits  = nbytes * 8;
        off    = 32'(i_addr_lo);

        unique case (size_eff)
            SizeByte: o_misaligned = 1'b0;
            SizeHalf: o_misaligned = i_addr_lo[0];
            default:  o_misaligned = |i_addr_lo[1:0];
        endcase

        for (int unsigned b = 0; b < NumBytes; b++) begin
            o_lane_mask[b] = (b >= off) && (b < off + nbytes);
        end

        // Little-endian: byte offset k lives in bits [8k+7:8k] of the word.
        o_wdata = i_wdata << {i_addr_lo, 3'b000};
        shifted = i_mem_word >> {i_addr_lo, 3'b000};

        unique case (size_eff)
            SizeByte: ext_bit = shifted[7];
            SizeHalf: ext_bit = shifted[15];
            default:  ext_bit = shifted[31];
        endcase
        ext_bit = ext_bit & ~unsigned_eff;

        for (int unsigned i = 0; i < XLEN; i++) begin
            o_rdata[i] = (i < nbits) ? shifted[i] : ext_bit;
        end
    end

endmodule

// File: rtl/mem_stage_ls.sv
// mem_stage_ls: load/store memory stage with a multi-cycle data memory.
//   Accepts one op per idle cycle, captures it, and completes it after LATENCY
//   cycles (memory ops) or one cycle (non-memory or misaligned ops). Completion
//   raises o_valid for one cycle; stores commit and loads sample on that edge.
//   Also resolves the branch decision (o_PCSrc) and the SLT/address result (o_Mux).
//   Build option MEM_STAGE_SUBWORD_EN enables byte/half accesses (see mem_ls_align).
// Parameters: XLEN datapath width, DEPTH memory words (power of two),
//             LATENCY memory-access cycles (>= 1).
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid                 op present
//   i_Address, i_WriteData  byte address / store data
//   i_MemWrite, i_MemRead   store / load (both set = store)
//   i_Size, i_Unsigned      access size, zero-extend loads
//   i_SLTc, i_negative      select SLT result for o_Mux
//   i_branch, i_BranchOp, i_zero  branch resolution
//   o_valid                 one-cycle completion pulse
//   o_stall                 stage busy with a memory access
//   o_PCSrc                 branch taken (only alongside o_valid)
//   o_misaligned            completed memory op was misaligned
//   o_ReadData, o_Mux       load result, SLT/address result
module mem_stage_ls
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN    = XlenDefault,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_Address,
    input  logic [XLEN-1:0] i_WriteData,
    input  logic            i_MemWrite,
    input  logic            i_MemRead,
    input  logic            i_Unsigned,
    input  logic            i_SLTc,
    input  logic            i_branch,
    input  logic            i_zero,
    input  logic            i_negative,
    input  logic [1:0]      i_Size,
    input  logic [1:0]      i_BranchOp,
    output logic            o_valid,
    output logic            o_stall,
    output logic            o_PCSrc,
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_ReadData,
    output logic [XLEN-1:0] o_Mux
);

    localparam int unsigned NumBytes = XLEN / 8;
    localparam int unsigned OffW     = $clog2(NumBytes);
    localparam int unsigned IdxW     = $clog2(DEPTH);
    localparam int unsigned CntW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // BUSY lasts LATENCY-1 cycles; the counter counts down to 0 inclusive.
    localparam logic [CntW-1:0] CntInit = CntW'((LATENCY > 1) ? LATENCY - 2 : 0);

    // FSM and counter
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Captured op
    logic [XLEN-1:0] op_addr_q, op_addr_d;
    logic [XLEN-1:0] op_wdata_q, op_wdata_d;
    logic            op_write_q, op_write_d;
    logic            op_read_q, op_read_d;
    logic            op_unsigned_q, op_unsigned_d;
    logic            op_sltc_q, op_sltc_d;
    logic            op_branch_q, op_branch_d;
    logic            op_zero_q, op_zero_d;
    logic            op_neg_q, op_neg_d;
    logic [1:0]      op_size_q, op_size_d;
    logic [1:0]      op_brop_q, op_brop_d;

    // Registered outputs
    logic            valid_q, valid_d;
    logic            pcsrc_q, pcsrc_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [XLEN-1:0] mux_q, mux_d;

    // Op currently being serviced: live inputs while idle, captured copy while busy
    logic [XLEN-1:0] cur_addr, cur_wdata;
    logic            cur_write, cur_read, cur_unsigned, cur_sltc;
    logic            cur_branch, cur_zero, cur_neg;
    logic [1:0]      cur_size, cur_brop;

    logic            busy, accept, is_mem, go_busy, done, mem_we;
    logic            misaligned;
    logic [IdxW-1:0] mem_idx;
    logic [XLEN-1:0] mem_word, st_data, ld_data;
    logic [NumBytes-1:0] lane_mask;

    logic [XLEN-1:0] mem_q [DEPTH];

    always_comb begin
        busy         = (state_q == StBusy);
        accept       = (state_q == StIdle) && i_valid;
        cur_addr     = busy ? op_addr_q     : i_Address;
        cur_wdata    = busy ? op_wdata_q    : i_WriteData;
        cur_write    = busy ? op_write_q    : i_MemWrite;
        cur_read     = busy ? op_read_q     : i_MemRead;
        cur_unsigned = busy ? op_unsigned_q : i_Unsigned;
        cur_sltc     = busy ? op_sltc_q     : i_SLTc;
        cur_branch   = busy ? op_branch_q   : i_branch;
        cur_zero     = busy ? op_zero_q     : i_zero;
        cur_neg      = busy ? op_neg_q      : i_negative;
        cur_size     = busy ? op_size_q     : i_Size;
        cur_brop     = busy ? op_brop_q     : i_BranchOp;
        // Higher address bits are ignored, so the memory wraps around.
        mem_idx      = cur_addr[IdxW+OffW-1:OffW];
        mem_word     = mem_q[mem_idx];
    end

    mem_ls_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_size       (cur_size),
        .i_unsigned   (cur_unsigned),
        .i_addr_lo    (cur_addr[OffW-1:0]),
        .i_wdata      (cur_wdata),
        .i_mem_word   (mem_word),
        .o_misaligned (misaligned),
        .o_lane_mask  (lane_mask),
        .o_wdata      (st_data),
        .o_rdata      (ld_data)
    );

    always_comb begin
        is_mem  = cur_write | cur_read;
        go_busy = accept && is_mem && !misaligned && (LATENCY > 1);
        // Misaligned ops never enter BUSY, so a busy op is always aligned.
        done    = (accept && !go_busy) || (busy && (cnt_q == '0));
        mem_we  = done && cur_write && !misaligned && !i_rst;

        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (go_busy) begin
                    state_d = StBusy;
                    cnt_d   = CntInit;
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase

        op_addr_d     = op_addr_q;
        op_wdata_d    = op_wdata_q;
        op_write_d    = op_write_q;
        op_read_d     = op_read_q;
        op_unsigned_d = op_unsigned_q;
        op_sltc_d     = op_sltc_q;
        op_branch_d   = op_branch_q;
        op_zero_d     = op_zero_q;
        op_neg_d      = op_neg_q;
        op_size_d     = op_size_q;
        op_brop_d     = op_brop_q;
        if (accept) begin
            op_addr_d     = i_Address;
            op_wdata_d    = i_WriteData;
            op_write_d    = i_MemWrite;
            op_read_d     = i_MemRead;
            op_unsigned_d = i_Unsigned;
            op_sltc_d     = i_SLTc;
            op_branch_d   = i_branch;
            op_zero_d     = i_zero;
            op_neg_d      = i_negative;
            op_size_d     = i_Size;
            op_brop_d     = i_BranchOp;
        end

        valid_d = done;
        pcsrc_d = done && cur_branch && branch_cond(branch_op_e'(cur_brop), cur_zero, cur_neg);
        mis_d   = mis_q;
        rdata_d = rdata_q;
        mux_d   = mux_q;
        if (done) begin
            mis_d   = is_mem && misaligned;
            rdata_d = (is_mem && !cur_write && !misaligned) ? ld_data : '0;
            mux_d   = cur_sltc ? {{(XLEN-1){1'b0}}, cur_neg} : cur_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            valid_q       <= 1'b0;
            pcsrc_q       <= 1'b0;
            mis_q         <= 1'b0;
            rdata_q       <= '0;
            mux_q         <= '0;
            op_addr_q     <= '0;
            op_wdata_q    <= '0;
            op_write_q    <= 1'b0;
            op_read_q     <= 1'b0;
            op_unsigned_q <= 1'b0;
            op_sltc_q     <= 1'b0;
            op_branch_q   <= 1'b0;
            op_zero_q     <= 1'b0;
            op_neg_q      <= 1'b0;
            op_size_q     <= 2'b00;
            op_brop_q     <= 2'b00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            valid_q       <= valid_d;
            pcsrc_q       <= pcsrc_d;
            mis_q         <= mis_d;
            rdata_q       <= rdata_d;
            mux_q         <= mux_d;
            op_addr_q     <= op_addr_d;
            op_wdata_q    <= op_wdata_d;
            op_write_q    <= op_write_d;
            op_read_q     <= op_read_d;
            op_unsigned_q <= op_unsigned_d;
            op_sltc_q     <= op_sltc_d;
            op_branch_q   <= op_branch_d;
            op_zero_q     <= op_zero_d;
            op_neg_q      <= op_neg_d;
            op_size_q     <= op_size_d;
            op_brop_q     <= op_brop_d;
        end
    end

    // Data memory is not reset; a reset only cancels the pending write.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (lane_mask[b]) begin
                    mem_q[mem_idx][b*8 +: 8] <= st_data[b*8 +: 8];
                end
            end
        end
    end

    assign o_valid      = valid_q;
    assign o_stall      = busy;
    assign o_PCSrc      = pcsrc_q;
    assign o_misaligned = mis_q;
    assign o_ReadData   = rdata_q;
    assign o_Mux        = mux_q;

endmodule

// File: tb/tb_mem_stage_ls.sv
// tb_mem_stage_ls: directed, table-driven bench for mem_stage_ls at default parameters
// (XLEN=32, DEPTH=256, LATENCY=2). Expected sub-word results follow MEM_STAGE_SUBWORD_EN.
module tb_mem_stage_ls;

`ifdef MEM_STAGE_SUBWORD_EN
    localparam bit SubEn = 1'b1;
`else
    localparam bit SubEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] addr, wdata;
    logic        mem_write, mem_read, uns, sltc, branch, zero, negative;
    logic [1:0]  size, brop;
    logic        valid_out, stall, pcsrc, misaligned;
    logic [31:0] read_data, mux_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_ls #(
        .XLEN    (32),
        .DEPTH   (256),
        .LATENCY (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid_in),
        .i_Address    (addr),
        .i_WriteData  (wdata),
        .i_MemWrite   (mem_write),
        .i_MemRead    (mem_read),
        .i_Unsigned   (uns),
        .i_SLTc       (sltc),
        .i_branch     (branch),
        .i_zero       (zero),
        .i_negative   (negative),
        .i_Size       (size),
        .i_BranchOp   (brop),
        .o_valid      (valid_out),
        .o_stall      (stall),
        .o_PCSrc      (pcsrc),
        .o_misaligned (misaligned),
        .o_ReadData   (read_data),
        .o_Mux        (mux_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr, rd, uns, sltc, br, zero, neg;
        logic [1:0]  size, brop;
        int          lat;
        logic [31:0] exp_rd;
        logic [31:0] exp_mux;
        logic        exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mem_op(string name, logic wr, logic rd, logic u, logic [1:0] sz,
                                    logic [31:0] a, logic [31:0] wd, int lat,
                                    logic [31:0] exp_rd, logic exp_mis);
        vec_t v;
        v.name = name; v.addr = a; v.wdata = wd; v.wr = wr; v.rd = rd; v.uns = u;
        v.sltc = 1'b0; v.br = 1'b0; v.zero = 1'b0; v.neg = 1'b0; v.size = sz; v.brop = 2'b00;
        v.lat = lat; v.exp_rd = exp_rd; v.exp_mux = a; v.exp_pc = 1'b0; v.exp_mis = exp_mis;
        return v;
    endfunction

    function automatic vec_t alu_op(string name, logic [31:0] a, logic s, logic br,
                                    logic [1:0] bop, logic z, logic n,
                                    logic [31:0] exp_mux, logic exp_pc);
        vec_t v;
        v.name = name; v.addr = a; v.wdata = 32'h0; v.wr = 1'b0; v.rd = 1'b0; v.uns = 1'b0;
        v.sltc = s; v.br = br; v.zero = z; v.neg = n; v.size = 2'b10; v.brop = bop;
        v.lat = 1; v.exp_rd = 32'h0; v.exp_mux = exp_mux; v.exp_pc = exp_pc; v.exp_mis = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        addr = v.addr; wdata = v.wdata; mem_write = v.wr; mem_read = v.rd; uns = v.uns;
        sltc = v.sltc; branch = v.br; zero = v.zero; negative = v.neg; size = v.size;
        brop = v.brop;
    endtask

    // Garbage on the op inputs after acceptance must not affect the op in flight.
    task automatic scramble();
        addr = $urandom; wdata = $urandom; mem_write = 1'($urandom); mem_read = 1'($urandom);
        uns = 1'($urandom); sltc = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom);
        negative = 1'($urandom); size = 2'($urandom); brop = 2'($urandom);
    endtask

    task automatic apply(input vec_t v);
        int  n;
        int  stalls;
        bit  got;
        @(negedge clk);
        drive(v);
        valid_in = 1'b1;
        n = 0; stalls = 0; got = 1'b0;
        while (!got && n < 16) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                valid_in = 1'b0;
                scramble();
            end
            if (stall) stalls++;
            if (valid_out) got = 1'b1;
        end
        check({v.name, " latency"}, n, v.lat);
        check({v.name, " stall_cycles"}, stalls, v.lat - 1);
        check({v.name, " ReadData"}, read_data, v.exp_rd);
        check({v.name, " Mux"}, mux_out, v.exp_mux);
        check({v.name, " PCSrc"}, pcsrc, v.exp_pc);
        check({v.name, " misaligned"}, misaligned, v.exp_mis);
        @(posedge clk); #1;
        check({v.name, " valid_one_cycle"}, valid_out, 1'b0);
        check({v.name, " PCSrc_cleared"}, pcsrc, 1'b0);
        check({v.name, " Mux_held"}, mux_out, v.exp_mux);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [31:0] seen_rd;

        rst = 1'b1; valid_in = 1'b0;
        addr = '0; wdata = '0; mem_write = 1'b0; mem_read = 1'b0; uns = 1'b0; sltc = 1'b0;
        branch = 1'b0; zero = 1'b0; negative = 1'b0; size = 2'b00; brop = 2'b00;

        vecs.push_back(mem_op("sw_deadbeef", 1, 0, 0, 2'b10, 32'h10, 32'hDEADBEEF, 2, 0, 0));
        vecs.push_back(mem_op("lw_10", 0, 1, 0, 2'b10, 32'h10, 0, 2, 32'hDEADBEEF, 0));
        vecs.push_back(mem_op("lbu_11", 0, 1, 1, 2'b00, 32'h11, 0, SubEn ? 2 : 1,
                              SubEn ? 32'h000000BE : 32'h0, !SubEn));
        vecs.push_back(mem_op("lb_13", 0, 1, 0, 2'b00, 32'h13, 0, SubEn ? 2 : 1,
                              SubEn ? 32'hFFFFFFDE : 32'h0, !SubEn));
        vecs.push_back(mem_op("lh_12", 0, 1, 0, 2'b01, 32'h12, 0, SubEn ? 2 : 1,
                              SubEn ? 32'hFFFFDEAD : 32'h0, !SubEn));
        vecs.push_back(mem_op("lhu_12", 0, 1, 1, 2'b01, 32'h12, 0, SubEn ? 2 : 1,
                              SubEn ? 32'h0000DEAD : 32'h0, !SubEn));
        vecs.push_back(mem_op("lbu_10", 0, 1, 1, 2'b00, 32'h10, 0, 2,
                              SubEn ? 32'h000000EF : 32'hDEADBEEF, 0));
        vecs.push_back(mem_op("lw_02_mis", 0, 1, 0, 2'b10, 32'h02, 0, 1, 0, 1));
        vecs.push_back(alu_op("blt_taken", 32'h100, 0, 1, 2'b10, 0, 1, 32'h100, 1));
        vecs.push_back(alu_op("bge_not", 32'h100, 0, 1, 2'b11, 0, 1, 32'h100, 0));
        vecs.push_back(alu_op("slt_set", 32'h55, 1, 0, 2'b00, 0, 1, 32'h1, 0));
        vecs.push_back(alu_op("slt_clr", 32'h55, 1, 0, 2'b00, 0, 0, 32'h0, 0));
        vecs.push_back(alu_op("beq_taken", 32'h200, 0, 1, 2'b00, 1, 0, 32'h200, 1));
        vecs.push_back(alu_op("bne_not", 32'h200, 0, 1, 2'b01, 1, 0, 32'h200, 0));
        vecs.push_back(alu_op("bne_nobranch", 32'h204, 0, 0, 2'b01, 0, 0, 32'h204, 0));
        vecs.push_back(mem_op("sw_alias_410", 1, 0, 0, 2'b10, 32'h410, 32'hCAFEF00D, 2, 0, 0));
        vecs.push_back(mem_op("lw_10_alias", 0, 1, 0, 2'b10, 32'h10, 0, 2, 32'hCAFEF00D, 0));
        vecs.push_back(mem_op("lw_810_alias", 0, 1, 0, 2'b10, 32'h810, 0, 2, 32'hCAFEF00D, 0));
        vecs.push_back(mem_op("sb_11", 1, 0, 0, 2'b00, 32'h11, 32'h123456AA, SubEn ? 2 : 1,
                              0, !SubEn));
        vecs.push_back(mem_op("sh_12", 1, 0, 0, 2'b01, 32'h12, 32'hABCD1234, SubEn ? 2 : 1,
                              0, !SubEn));
        vecs.push_back(mem_op("lw_10_lanes", 0, 1, 0, 2'b10, 32'h10, 0, 2,
                              SubEn ? 32'h1234AA0D : 32'hCAFEF00D, 0));
        vecs.push_back(mem_op("sw_rw_30", 1, 1, 0, 2'b10, 32'h30, 32'h11223344, 2, 0, 0));
        vecs.push_back(mem_op("lw_30", 0, 1, 0, 2'b10, 32'h30, 0, 2, 32'h11223344, 0));
        vecs.push_back(mem_op("sw_31_mis", 1, 0, 0, 2'b10, 32'h31, 32'h99999999, 1, 0, 1));
        vecs.push_back(mem_op("lw_30_kept", 0, 1, 0, 2'b10, 32'h30, 0, 2, 32'h11223344, 0));
        vecs.push_back(mem_op("lrsvd_30", 0, 1, 0, 2'b11, 32'h30, 0, 2, 32'h11223344, 0));
        vecs.push_back(mem_op("lrsvd_32_mis", 0, 1, 0, 2'b11, 32'h32, 0, 1, 0, 1));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", valid_out, 1'b0);
        check("reset stall", stall, 1'b0);
        check("reset PCSrc", pcsrc, 1'b0);
        check("reset misaligned", misaligned, 1'b0);
        check("reset ReadData", read_data, 32'h0);
        check("reset Mux", mux_out, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset while BUSY cancels the pending store
        apply(mem_op("sw_20_init", 1, 0, 0, 2'b10, 32'h20, 32'h0BADF00D, 2, 0, 0));
        @(negedge clk);
        drive(mem_op("sw_20_cancel", 1, 0, 0, 2'b10, 32'h20, 32'h12345678, 2, 0, 0));
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("rst_busy stall", stall, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy stall_cleared", stall, 1'b0);
        check("rst_busy Mux_cleared", mux_out, 32'h0);
        pulses = (valid_out === 1'b1) ? 1 : 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (valid_out === 1'b1) pulses++;
        end
        check("rst_busy no_valid", pulses, 0);
        apply(mem_op("lw_20_prev", 0, 1, 0, 2'b10, 32'h20, 0, 2, 32'h0BADF00D, 0));

        // Reset has priority over acceptance
        apply(mem_op("sw_40_init", 1, 0, 0, 2'b10, 32'h40, 32'h5A5A5A5A, 2, 0, 0));
        @(negedge clk);
        drive(mem_op("sw_40_blocked", 1, 0, 0, 2'b10, 32'h40, 32'h77777777, 2, 0, 0));
        valid_in = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        rst = 1'b0;
        check("rst_prio stall", stall, 1'b0);
        pulses = (valid_out === 1'b1) ? 1 : 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (valid_out === 1'b1) pulses++;
        end
        check("rst_prio no_valid", pulses, 0);
        apply(mem_op("lw_40_prev", 0, 1, 0, 2'b10, 32'h40, 0, 2, 32'h5A5A5A5A, 0));

        // i_valid held through BUSY: only one op is taken
        @(negedge clk);
        drive(mem_op("lw_30_hold", 0, 1, 0, 2'b10, 32'h30, 0, 2, 0, 0));
        valid_in = 1'b1;
        pulses  = 0;
        seen_rd = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 2) valid_in = 1'b0;
            if (valid_out === 1'b1) begin
                pulses++;
                seen_rd = read_data;
            end
        end
        check("hold_valid pulses", pulses, 1);
        check("hold_valid ReadData", seen_rd, 32'h11223344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
